// File: rtl/iob_vexriscv_pkg.sv
// Shared definitions for the VexRiscv-to-IOb bus bridge.
//   state_t        : bridge FSM encoding (idle / one IOb access outstanding)
//   BOOT_ADDR_XOR  : address remap used by the instruction-bus instance so
//                    that the core's reset vector lands on the boot memory
//   TMO_CNT_W      : width of the aborted-access counter output
package iob_vexriscv_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [31:0] BOOT_ADDR_XOR = 32'h8000_0000;

    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/iob_vexriscv_bus_bridge_if.sv
// Signal bundle between a VexRiscv cmd/rsp port, the bridge and the IOb side.
//   cmd_*  : core command channel (valid/ready handshake)
//   rsp_*  : read response back to the core (single-cycle pulse)
//   iob_*  : IOb native request (valid/addr/wdata/wstrb) and completion (ready/rdata)
// Modports:
//   master : the bridge itself, which is the IOb master and the cmd consumer
//   slave  : everything around it (core wrapper plus IOb interconnect)
interface iob_vexriscv_bus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_W-1:0]     cmd_address;
    logic [DATA_W-1:0]     cmd_data;
    logic [DATA_W/8-1:0]   cmd_mask;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_error;

    logic                  iob_valid;
    logic [ADDR_W-1:0]     iob_addr;
    logic [DATA_W-1:0]     iob_wdata;
    logic [DATA_W/8-1:0]   iob_wstrb;
    logic                  iob_ready;
    logic [DATA_W-1:0]     iob_rdata;

    modport master (
        input  cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask,
        input  iob_ready, iob_rdata,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_error,
        output iob_valid, iob_addr, iob_wdata, iob_wstrb
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_address, cmd_data, cmd_mask,
        output iob_ready, iob_rdata,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_error,
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb
    );

endinterface

// File: rtl/iob_vexriscv_cmd_fifo.sv
// Command buffer for the bus bridge: synchronous FIFO with first-word
// fall-through read (dout is the head entry whenever !empty).
//   clk, rst : clock, asynchronous active-low reset (empties the FIFO)
//   push/din : write one entry; ignored while full
//   pop/dout : drop the head entry; ignored while empty
//   full/empty
// A push that coincides with a pop while full is refused: full is a pure
// function of the pointers, so the freed slot is only visible next cycle.
module iob_vexriscv_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_en;
    logic         pop_en;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/iob_vexriscv_bus_bridge.sv
// Bridge from one VexRiscv cmd/rsp port (iBus or dBus) to an IOb native master.
//   clk         : clock
//   rst         : asynchronous active-low reset
//   bus         : cmd/rsp channel from the core and IOb request/completion
//   timeout_cnt : saturating count of accesses aborted by the timeout
// Commands are buffered in a small FIFO; at most one IOb access is in flight.
// Every address is XORed with ADDR_XOR. An access that sees no iob_ready for
// 2**TIMEOUT_W-1 cycles is abandoned; a read then returns an error response.
module iob_vexriscv_bus_bridge
    import iob_vexriscv_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] ADDR_XOR = '0,
    parameter int              TIMEOUT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    iob_vexriscv_bus_bridge_if.master bus,
    output logic [TMO_CNT_W-1:0]   timeout_cnt
);
    localparam int STRB_W = DATA_W / 8;
    localparam int FIFO_W = 1 + ADDR_W + DATA_W + STRB_W;

    function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t              state;
    state_t              state_nxt;

    logic                rst_done;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_W-1:0]   fifo_dout;

    logic                head_wr;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [STRB_W-1:0]   head_mask;
    logic                head_skip;

    logic                load;
    logic                done;
    logic                abort;
    logic                acc_wr;
    logic [TIMEOUT_W-1:0] tmo;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic                tmo_expire;

    iob_vexriscv_cmd_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({bus.cmd_wr, bus.cmd_address, bus.cmd_data, bus.cmd_mask}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_wr, head_addr, head_data, head_mask} = fifo_dout;

    // A write with no byte enabled has nothing to do on the bus: retire it in IDLE.
    assign head_skip = head_wr && (head_mask == '0);

    // Holds cmd_ready low while in reset and for the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_done <= 1'b0;
        else      rst_done <= 1'b1;
    end

    assign bus.cmd_ready = rst_done && !fifo_full;
    assign fifo_push     = bus.cmd_valid && bus.cmd_ready;

    // Counter starts at 0 on entry; the access is abandoned on the edge
    // where it would reach all-ones, giving 2**TIMEOUT_W-1 request cycles.
    assign tmo_inc    = tmo + 1'b1;
    assign tmo_expire = (tmo_inc == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!fifo_empty && !head_skip) state_nxt = ST_ACCESS;
            ST_ACCESS: if (bus.iob_ready || tmo_expire) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = 1'b0;
        load     = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            ST_IDLE: begin
                fifo_pop = !fifo_empty;
                load     = !fifo_empty && !head_skip;
            end
            ST_ACCESS: begin
                // iob_ready beats a timeout landing on the same cycle.
                done  = bus.iob_ready;
                abort = !bus.iob_ready && tmo_expire;
            end
            default: ;
        endcase
    end

    // Decoded from the state register so that reset drops it asynchronously.
    assign bus.iob_valid = (state == ST_ACCESS);

    // ---- request register: captured on pop, held for the whole access ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_wr        <= 1'b0;
            bus.iob_addr  <= '0;
            bus.iob_wdata <= '0;
            bus.iob_wstrb <= '0;
            tmo           <= '0;
        end else begin
            if (load) begin
                acc_wr        <= head_wr;
                bus.iob_addr  <= head_addr ^ ADDR_XOR;
                bus.iob_wdata <= head_data;
                bus.iob_wstrb <= head_wr ? head_mask : '0;
                tmo           <= '0;
            end else if (state == ST_ACCESS) begin
                tmo <= tmo_inc;
            end
        end
    end

    // ---- response register: one cycle after completion or abort ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            bus.rsp_data  <= '0;
            timeout_cnt   <= '0;
        end else begin
            bus.rsp_valid <= (done || abort) && !acc_wr;
            bus.rsp_error <= abort && !acc_wr;
            if (done && !acc_wr)       bus.rsp_data <= bus.iob_rdata;
            else if (abort && !acc_wr) bus.rsp_data <= '0;
            if (abort) timeout_cnt <= sat_inc(timeout_cnt);
        end
    end

endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
module tb_iob_vexriscv_bus_bridge;
    localparam logic [31:0] XORV = 32'h8000_0000;
    localparam int NEVER = -1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wr;
        int          delay;
        logic [31:0] rdata;
        int          exp_len;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int stalls   = 0;

    req_t req_q[$];
    rsp_t rsp_q[$];

    iob_vexriscv_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    iob_vexriscv_bus_bridge #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (2),
        .ADDR_XOR   (XORV),
        .TIMEOUT_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_req(input logic wr, input logic [31:0] caddr, input logic [31:0] d,
                              input logic [3:0] m, input int delay, input logic [31:0] rdata,
                              input int exp_len);
        req_t r;
        r.addr    = caddr ^ XORV;
        r.wdata   = d;
        r.wstrb   = wr ? m : 4'h0;
        r.wr      = wr;
        r.delay   = delay;
        r.rdata   = rdata;
        r.exp_len = exp_len;
        req_q.push_back(r);
    endtask

    task automatic expect_rsp(input logic [31:0] d, input logic e);
        rsp_t r;
        r.data = d;
        r.err  = e;
        rsp_q.push_back(r);
    endtask

    // Called at a negedge; leaves cmd_valid high so calls can stream.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        n = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_wr      = wr;
        bus.cmd_address = a;
        bus.cmd_data    = d;
        bus.cmd_mask    = m;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (n >= 50) check("cmd_accept_bound", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // IOb slave model: checks each request against the queue and answers
    // after the requested number of cycles (or never).
    logic slave_busy = 1'b0;
    int   slave_cnt  = 0;
    req_t cur;

    initial begin
        bus.iob_ready = 1'b0;
        bus.iob_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.iob_valid) begin
                if (!slave_busy) begin
                    slave_busy = 1'b1;
                    slave_cnt  = 0;
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL iob_unexpected_req: actual addr=%h required=no request", bus.iob_addr);
                        cur.delay   = NEVER;
                        cur.exp_len = 0;
                        cur.addr    = bus.iob_addr;
                        cur.wstrb   = bus.iob_wstrb;
                        cur.wr      = 1'b0;
                    end else begin
                        cur = req_q.pop_front();
                        if (cur.wr) check("iob_wdata", bus.iob_wdata, cur.wdata);
                    end
                end
                check("iob_addr", bus.iob_addr, cur.addr);
                check("iob_wstrb", 32'(bus.iob_wstrb), 32'(cur.wstrb));
                bus.iob_ready = (slave_cnt == cur.delay);
                bus.iob_rdata = (slave_cnt == cur.delay) ? cur.rdata : 32'h5A5A_5A5A;
                slave_cnt++;
            end else begin
                if (slave_busy && cur.exp_len != 0)
                    check("iob_valid_len", 32'(slave_cnt), 32'(cur.exp_len));
                slave_busy    = 1'b0;
                bus.iob_ready = 1'b0;
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: actual data=%h err=%0d required=no response",
                             bus.rsp_data, bus.rsp_error);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_data", bus.rsp_data, r.data);
                    check("rsp_error", 32'(bus.rsp_error), 32'(r.err));
                end
            end
        end
    end

    initial begin
        int n;
        int vcount;
        bus.cmd_valid   = 1'b0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_address = 32'h0;
        bus.cmd_data    = 32'h0;
        bus.cmd_mask    = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_iob_valid", 32'(bus.iob_valid), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Plain read, slave answers on the 4th request cycle
        expect_req(1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 32'hDEAD_BEEF, 4);
        expect_rsp(32'hDEAD_BEEF, 1'b0);
        send(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        idle(10);

        // Write through the boot remap
        expect_req(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 1, 32'h0, 2);
        send(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
        idle(10);

        // Read that never completes
        expect_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, NEVER, 32'h0, 15);
        expect_rsp(32'h0, 1'b1);
        send(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        idle(25);
        check("timeout_cnt_1", 32'(timeout_cnt), 32'd1);

        // Streaming reads with a 1-cycle slave
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            expect_req(1'b0, 32'h0000_0200 + 32'(4*i), 32'h0, 4'h0, 0, 32'h1111_1111 * (i+1), 1);
            expect_rsp(32'h1111_1111 * (i+1), 1'b0);
        end
        for (int i = 0; i < 4; i++) send(1'b0, 32'h0000_0200 + 32'(4*i), 32'h0, 4'h0);
        check("stream_stalled", 32'(stalls != 0), 32'd1);
        idle(20);

        // Zero-mask write is dropped; following read proceeds
        expect_req(1'b0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 3);
        expect_rsp(32'hCAFE_F00D, 1'b0);
        send(1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0);
        send(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        idle(15);

        // Reset in the middle of an access, with a second command buffered
        expect_req(1'b0, 32'h0000_0050, 32'h0, 4'h0, NEVER, 32'h0, 0);
        send(1'b0, 32'h0000_0050, 32'h0, 4'h0);
        send(1'b0, 32'h0000_0058, 32'h0, 4'h0);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.iob_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_valid_seen", 32'(bus.iob_valid), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_mid_async_drop", 32'(bus.iob_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rel_timeout_cnt", 32'(timeout_cnt), 32'd0);
        vcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.iob_valid || bus.rsp_valid) vcount++;
        end
        check("rst_fifo_flushed", 32'(vcount), 32'd0);

        // Normal operation after reset
        expect_req(1'b0, 32'h0000_0060, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 2);
        expect_rsp(32'h0BAD_F00D, 1'b0);
        send(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        idle(2);

        n = 0;
        while ((req_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        idle(3);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
